// File: rtl/weight_ctrl_pkg.sv
// Shared definitions for the gate weight RAM controller: state encoding,
// default geometry and the address-width helper.
package weight_ctrl_pkg;

    localparam int DEF_NROW     = 16;
    localparam int DEF_NCOL     = 16;
    localparam int DEF_BITWIDTH = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_SWEEP
    } state_e;

    // Ceiling log2, never below 1 so a depth of 1 still yields a usable port.
    function automatic int log2_ceil(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_row_packer.sv
// Collects NROW stream words into one RAM row; slice n holds beat n of the
// current column. rowFull flags the beat that completes the row.
module weight_row_packer
    import weight_ctrl_pkg::*;
#(
    parameter int NROW     = DEF_NROW,
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     beat_i,
    input  logic [BITWIDTH-1:0]      word_i,
    output logic [NROW*BITWIDTH-1:0] row_o,
    output logic                     row_full_o
);

    localparam int WCW = log2_ceil(NROW);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NROW - 1);

    logic [WCW-1:0]           word_q, word_d;
    logic [NROW*BITWIDTH-1:0] row_q;

    assign row_full_o = beat_i && (word_q == LAST_WORD);
    assign row_o      = row_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word_d = word_q;
        if (clear_i) begin
            word_d = '0;
        end else if (beat_i) begin
            word_d = (word_q == LAST_WORD) ? '0 : word_q + 1'b1;
        end
    end

    // The row register is reset too, so a reset discards any partial row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            row_q  <= '0;
        end else begin
            word_q <= word_d;
            if (beat_i) begin
                for (int i = 0; i < NROW; i++) begin
                    if (word_q == WCW'(i)) row_q[i*BITWIDTH +: BITWIDTH] <= word_i;
                end
            end
        end
    end

endmodule

// File: rtl/weight_ram_ctrl.sv
// Load/sweep sequencer for the gate weight RAM. Owns every RAM control pin;
// all outputs are registered and derived from the next state.
module weight_ram_ctrl
    import weight_ctrl_pkg::*;
#(
    parameter  int NROW          = DEF_NROW,
    parameter  int NCOL          = DEF_NCOL,
    parameter  int BITWIDTH      = DEF_BITWIDTH,
    localparam int ADDR_BITWIDTH = log2_ceil(NCOL)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     loadStart,
    input  logic                     sweepStart,
    input  logic [BITWIDTH-1:0]      wordIn,
    input  logic                     wordValid,
    output logic                     wordReady,
    output logic                     ramWriteEn,
    output logic [ADDR_BITWIDTH-1:0] ramAddressIn,
    output logic [ADDR_BITWIDTH-1:0] ramAddressOut,
    output logic [NROW*BITWIDTH-1:0] ramRowIn,
    output logic                     colValid,
    output logic [ADDR_BITWIDTH-1:0] colIndex,
    output logic                     busy,
    output logic                     loadDone,
    output logic                     sweepDone
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

    state_e                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] col_q, col_d;
    logic                     pending_q, pending_d;
    logic                     packer_clear, beat, row_full;

    logic                     word_ready_q, word_ready_d;
    logic                     write_en_q, write_en_d;
    logic [ADDR_BITWIDTH-1:0] addr_in_q, addr_in_d;
    logic [ADDR_BITWIDTH-1:0] addr_out_q, addr_out_d;
    logic                     col_valid_q, col_valid_d;
    logic [ADDR_BITWIDTH-1:0] col_index_q, col_index_d;
    logic                     busy_q, busy_d;
    logic                     load_done_q, load_done_d;
    logic                     sweep_done_q, sweep_done_d;

    assign beat = wordValid && word_ready_q;

    weight_row_packer #(
        .NROW     (NROW),
        .BITWIDTH (BITWIDTH)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (packer_clear),
        .beat_i     (beat),
        .word_i     (wordIn),
        .row_o      (ramRowIn),
        .row_full_o (row_full)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        pending_d    = pending_q;
        packer_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (loadStart) begin
                    state_d      = ST_LOAD;
                    col_d        = '0;
                    packer_clear = 1'b1;
                    if (sweepStart) pending_d = 1'b1;
                end else if (sweepStart || pending_q) begin
                    state_d   = ST_SWEEP;
                    col_d     = '0;
                    pending_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (sweepStart) pending_d = 1'b1;
                if (row_full)   state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (sweepStart) pending_d = 1'b1;
                if (col_q == LAST_COL) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                    col_d   = col_q + 1'b1;
                end
            end
            ST_SWEEP: begin
                if (col_q == LAST_COL) state_d = ST_IDLE;
                else                   col_d = col_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers track the state being entered, so they line up with it.
    always_comb begin
        word_ready_d = (state_d == ST_LOAD);
        write_en_d   = (state_d == ST_WRITE);
        addr_in_d    = (state_d == ST_WRITE) ? col_d : addr_in_q;
        addr_out_d   = (state_d == ST_SWEEP) ? col_d : addr_out_q;
        col_valid_d  = (state_d == ST_SWEEP);
        col_index_d  = (state_d == ST_SWEEP) ? col_d : col_index_q;
        busy_d       = (state_d != ST_IDLE);
        load_done_d  = (state_q == ST_WRITE) && (col_q == LAST_COL);
        sweep_done_d = (state_q == ST_SWEEP) && (col_q == LAST_COL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            pending_q    <= 1'b0;
            word_ready_q <= 1'b0;
            write_en_q   <= 1'b0;
            addr_in_q    <= '0;
            addr_out_q   <= '0;
            col_valid_q  <= 1'b0;
            col_index_q  <= '0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            pending_q    <= pending_d;
            word_ready_q <= word_ready_d;
            write_en_q   <= write_en_d;
            addr_in_q    <= addr_in_d;
            addr_out_q   <= addr_out_d;
            col_valid_q  <= col_valid_d;
            col_index_q  <= col_index_d;
            busy_q       <= busy_d;
            load_done_q  <= load_done_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign wordReady     = word_ready_q;
    assign ramWriteEn    = write_en_q;
    assign ramAddressIn  = addr_in_q;
    assign ramAddressOut = addr_out_q;
    assign colValid      = col_valid_q;
    assign colIndex      = col_index_q;
    assign busy          = busy_q;
    assign loadDone      = load_done_q;
    assign sweepDone     = sweep_done_q;

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Directed bench for weight_ram_ctrl at NROW=NCOL=4; a falling-edge RAM model
// captures writes and serves sweep reads, checked against hand-computed rows.
module tb_weight_ram_ctrl;

    localparam int NROW = 4;
    localparam int NCOL = 4;
    localparam int BW   = 18;
    localparam int AW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 loadStart, sweepStart, wordValid;
    logic [BW-1:0]        wordIn;
    logic                 wordReady, ramWriteEn, colValid, busy, loadDone, sweepDone;
    logic [AW-1:0]        ramAddressIn, ramAddressOut, colIndex;
    logic [NROW*BW-1:0]   ramRowIn;

    weight_ram_ctrl #(
        .NROW     (NROW),
        .NCOL     (NCOL),
        .BITWIDTH (BW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .loadStart     (loadStart),
        .sweepStart    (sweepStart),
        .wordIn        (wordIn),
        .wordValid     (wordValid),
        .wordReady     (wordReady),
        .ramWriteEn    (ramWriteEn),
        .ramAddressIn  (ramAddressIn),
        .ramAddressOut (ramAddressOut),
        .ramRowIn      (ramRowIn),
        .colValid      (colValid),
        .colIndex      (colIndex),
        .busy          (busy),
        .loadDone      (loadDone),
        .sweepDone     (sweepDone)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [NROW*BW-1:0] ram_model [NCOL];
    int cyc, base, word_idx;
    int wr_cnt, cv_cnt, ld_cnt, sd_cnt, ld_cyc, sd_cyc, first_cv;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Word for row i of column c is base + NROW*c + i + 1.
    function automatic logic [NROW*BW-1:0] exp_row(input int b, input int c);
        logic [NROW*BW-1:0] r;
        for (int i = 0; i < NROW; i++) r[i*BW +: BW] = BW'(b + NROW*c + i + 1);
        return r;
    endfunction

    task automatic observe();
        if (ramWriteEn) begin
            check("wr_addr", 128'(ramAddressIn), 128'(wr_cnt));
            check("wr_row", 128'(ramRowIn), 128'(exp_row(base, wr_cnt)));
            check("wr_ready_low", 128'(wordReady), 128'(0));
            ram_model[ramAddressIn] = ramRowIn;
            wr_cnt++;
        end
        if (colValid) begin
            if (first_cv < 0) first_cv = cyc;
            check("col_index", 128'(colIndex), 128'(cv_cnt));
            check("col_addr", 128'(ramAddressOut), 128'(cv_cnt));
            check("col_data", 128'(ram_model[ramAddressOut]), 128'(exp_row(base, cv_cnt)));
            check("busy_sweep", 128'(busy), 128'(1));
            cv_cnt++;
        end
        if (loadDone) begin
            ld_cyc = cyc;
            ld_cnt++;
        end
        if (sweepDone) begin
            sd_cyc = cyc;
            sd_cnt++;
        end
        if (wordValid && wordReady) word_idx++;
    endtask

    // Inputs for the current cycle are already driven; observe it, then step.
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_counters();
        cyc = 0; word_idx = 0;
        wr_cnt = 0; cv_cnt = 0; ld_cnt = 0; sd_cnt = 0;
        ld_cyc = -1; sd_cyc = -1; first_cv = -1;
    endtask

    task automatic run_load(input int base_i, input bit toggle, input bit sw0,
                            input bit swmid, input int exp_ld, input bit exp_sweep);
        clear_counters();
        base = base_i;
        for (int c = 0; c < NCOL; c++) ram_model[c] = '0;
        loadStart = 1'b1; sweepStart = sw0; wordValid = 1'b0;
        tick();
        loadStart = 1'b0; sweepStart = 1'b0;
        for (int n = 0; n < 120 && !(ld_cnt > 0 && (!exp_sweep || sd_cnt > 0)); n++) begin
            wordValid  = toggle ? cyc[0] : 1'b1;
            wordIn     = BW'(base + word_idx + 1);
            sweepStart = swmid && (cyc == 8 || cyc == 12);
            tick();
        end
        wordValid = 1'b0; sweepStart = 1'b0;
        repeat (6) tick();
        check("load_done_cycle", 128'(ld_cyc), 128'(exp_ld));
        check("load_done_count", 128'(ld_cnt), 128'(1));
        check("write_count", 128'(wr_cnt), 128'(NCOL));
        check("words_consumed", 128'(word_idx), 128'(NROW*NCOL));
        for (int c = 0; c < NCOL; c++) check("ram_image", 128'(ram_model[c]), 128'(exp_row(base, c)));
        if (exp_sweep) begin
            check("pend_first_col", 128'(first_cv), 128'(exp_ld + 1));
            check("pend_col_count", 128'(cv_cnt), 128'(NCOL));
            check("pend_sweep_done", 128'(sd_cyc), 128'(exp_ld + NCOL + 1));
            check("pend_sweep_count", 128'(sd_cnt), 128'(1));
        end else begin
            check("no_sweep", 128'(cv_cnt), 128'(0));
        end
        check("idle_after_load", 128'(busy), 128'(0));
    endtask

    task automatic run_sweep(input bit disturb);
        clear_counters();
        sweepStart = 1'b1;
        tick();
        sweepStart = 1'b0;
        for (int n = 0; n < 10; n++) begin
            loadStart  = disturb && (cyc == 2);
            sweepStart = disturb && (cyc == 2);
            tick();
        end
        loadStart = 1'b0; sweepStart = 1'b0;
        check("sweep_first_col", 128'(first_cv), 128'(1));
        check("sweep_col_count", 128'(cv_cnt), 128'(NCOL));
        check("sweep_done_cycle", 128'(sd_cyc), 128'(NCOL + 1));
        check("sweep_done_count", 128'(sd_cnt), 128'(1));
        check("sweep_no_write", 128'(wr_cnt), 128'(0));
        check("sweep_no_load", 128'(ld_cnt), 128'(0));
        check("idle_after_sweep", 128'(busy), 128'(0));
    endtask

    initial begin
        reset = 1'b1; loadStart = 1'b0; sweepStart = 1'b0; wordValid = 1'b0; wordIn = '0;
        clear_counters();
        base = 0;
        for (int c = 0; c < NCOL; c++) ram_model[c] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 128'({busy, wordReady, ramWriteEn, colValid, loadDone, sweepDone}), 128'(0));
        check("reset_addr", 128'({ramAddressIn, ramAddressOut, colIndex}), 128'(0));
        check("reset_row", 128'(ramRowIn), 128'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_load(0, 1'b0, 1'b0, 1'b0, NCOL*(NROW+1) + 1, 1'b0);
        run_sweep(1'b0);
        run_load('h100, 1'b1, 1'b0, 1'b0, 33, 1'b0);
        run_sweep(1'b1);
        run_load('h200, 1'b0, 1'b1, 1'b1, NCOL*(NROW+1) + 1, 1'b1);

        // Abort a load after six beats with an asynchronous reset.
        clear_counters();
        base = 'h300;
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        for (int n = 0; n < 40 && word_idx < 6; n++) begin
            wordValid = 1'b1;
            wordIn    = BW'(base + word_idx + 1);
            tick();
        end
        check("pre_reset_ready", 128'(wordReady), 128'(1));
        reset = 1'b1; wordValid = 1'b0;
        #1;
        check("async_rst_ctrl", 128'({busy, wordReady, ramWriteEn, colValid, loadDone, sweepDone}), 128'(0));
        check("async_rst_addr", 128'({ramAddressIn, ramAddressOut, colIndex}), 128'(0));
        check("async_rst_row", 128'(ramRowIn), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_load('h400, 1'b0, 1'b0, 1'b0, NCOL*(NROW+1) + 1, 1'b0);
        run_sweep(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
